// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: fixed-latency multiply, radix-2 restoring divide,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int data_width = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    output logic [data_width-1:0] result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  div_by_zero,
    output logic                  hold_pipeline
);

    localparam int N      = data_width;
    localparam int PW     = 2 * N;
    localparam int CW_DIV = $clog2(N);
    localparam int CW_MUL = $clog2(MUL_CYCLES + 1);
    localparam int CW     = (CW_DIV > CW_MUL) ? CW_DIV : CW_MUL;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic [N-1:0]   result_q, result_d;
    logic           dbz_q, dbz_d;

    logic signed [PW+1:0] mul_a_ext, mul_b_ext;
    logic [PW-1:0]        prod;
    logic [N:0]           rem_sh, diff;

    function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic is_signed);
        return cond_neg(v, is_signed & v[N-1]);
    endfunction

    // Operand A is signed for every mul op except MULHU; B only for MULH. MUL's low half is sign-agnostic.
    assign mul_a_ext = {{(N+2){a_q[N-1] & (op_q != 2'b11)}}, a_q};
    assign mul_b_ext = {{(N+2){b_q[N-1] & (op_q == 2'b01)}}, b_q};
    assign prod      = PW'(mul_a_ext * mul_b_ext);

    // Restoring step: a_q doubles as the dividend shifter and the quotient accumulator.
    assign rem_sh = {rem_q, a_q[N-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d = op[1:0];
                    if (!op[2]) begin
                        state_d = S_MUL;
                        a_d     = operand_A;
                        b_d     = operand_B;
                        cnt_d   = CW'(MUL_CYCLES - 1);
                    end else if (operand_B == '0) begin
                        state_d  = S_DONE;
                        result_d = op[1] ? operand_A : '1;
                        dbz_d    = 1'b1;
                    end else if (!op[0] && operand_A == MIN_VAL && operand_B == '1) begin
                        state_d  = S_DONE;
                        result_d = op[1] ? '0 : operand_A;
                        dbz_d    = 1'b0;
                    end else begin
                        state_d = S_DIV;
                        a_d     = magnitude(operand_A, ~op[0]);
                        b_d     = magnitude(operand_B, ~op[0]);
                        rem_d   = '0;
                        qneg_d  = ~op[0] & (operand_A[N-1] ^ operand_B[N-1]);
                        rneg_d  = ~op[0] & operand_A[N-1];
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = (op_q == 2'b00) ? prod[N-1:0] : prod[PW-1:N];
                    dbz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff[N]) begin
                        rem_d = diff[N-1:0];
                        a_d   = {a_q[N-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[N-1:0];
                        a_d   = {a_q[N-2:0], 1'b0};
                    end
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = op_q[1] ? cond_neg(rem_q, rneg_q) : cond_neg(a_q, qneg_q);
                    dbz_d    = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result        = result_q;
    assign div_by_zero   = dbz_q;
    assign result_valid  = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign hold_pipeline = (start & (state_q == S_IDLE) & ~flush) | (busy & (state_q != S_DONE));

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases, randomized ops against an
// arithmetic reference model, flush, held start and asynchronous reset scenarios.
module tb_muldiv_unit;

    localparam int N  = 32;
    localparam int MC = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [N-1:0] operand_A = '0;
    logic [N-1:0] operand_B = '0;
    logic [N-1:0] result;
    logic         result_valid, busy, div_by_zero, hold_pipeline;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] last_res = '0;

    muldiv_unit #(.data_width(N), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .operand_A(operand_A), .operand_B(operand_B), .result(result),
        .result_valid(result_valid), .busy(busy), .div_by_zero(div_by_zero),
        .hold_pipeline(hold_pipeline)
    );

    always #5 clk = ~clk;

    // Reference: full 64-bit products and SV's truncating signed division.
    function automatic logic [N-1:0] ref_result(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        logic signed [N-1:0] as, bs;
        sa = {{32{a[31]}}, a}; ua = {32'd0, a};
        sb = {{32{b[31]}}, b}; ub = {32'd0, b};
        as = a; bs = b;
        case (o)
            3'd0: begin p = sa * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return as / bs;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return as % bs;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        if (!o[2]) return MC + 1;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return N + 2;
    endfunction

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 100) begin next_cycle(); n++; end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] exp_res;
        logic         exp_dbz;
        int           exp_lat, lat;
        logic         hold_ok;
        exp_res = ref_result(o, a, b);
        exp_lat = ref_latency(o, a, b);
        exp_dbz = o[2] && (b == 0);
        wait_idle();
        start = 1'b1; op = o; operand_A = a; operand_B = b;
        #1;
        total++;
        if (hold_pipeline !== 1'b1) begin
            bad++; $display("FAIL %s hold_at_accept: got %b want 1", name, hold_pipeline);
        end
        next_cycle();
        start = 1'b0; operand_A = $urandom; operand_B = $urandom; op = 3'($urandom_range(0, 7));
        lat = 1; hold_ok = 1'b1;
        while (result_valid !== 1'b1 && lat < 60) begin
            if (hold_pipeline !== 1'b1) hold_ok = 1'b0;
            next_cycle(); lat++;
        end
        total++;
        if (lat != exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        total++;
        if (result !== exp_res) begin
            bad++; $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", name, result, exp_res, o, a, b);
        end
        total++;
        if (div_by_zero !== exp_dbz) begin
            bad++; $display("FAIL %s div_by_zero: got %b want %b", name, div_by_zero, exp_dbz);
        end
        total++;
        if (!hold_ok || hold_pipeline !== 1'b0) begin
            bad++; $display("FAIL %s hold_profile: busy-phase ok=%b done-phase hold=%b want 1/0", name, hold_ok, hold_pipeline);
        end
        last_res = exp_res;
        next_cycle();
        total++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            bad++; $display("FAIL %s after_done: valid=%b busy=%b result=%h want 0/0/%h", name, result_valid, busy, result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || hold_pipeline !== 1'b0) begin
            bad++; $display("FAIL reset_state: result=%h valid=%b busy=%b dbz=%b hold=%b want all 0", result, result_valid, busy, div_by_zero, hold_pipeline);
        end
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_directed();
        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu_min", 3'd3, 32'h8000_0000, 32'h8000_0000);
        run_op("div_m20_3", 3'd4, 32'hFFFF_FFEC, 32'd3);
        run_op("rem_m20_3", 3'd6, 32'hFFFF_FFEC, 32'd3);
        run_op("divu_max_2", 3'd5, 32'hFFFF_FFFF, 32'd2);
        run_op("divu_zero", 3'd5, 32'd123, 32'd0);
        run_op("remu_zero", 3'd7, 32'd123, 32'd0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_min_m1", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [N-1:0] a, b;
        int           sel;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'd1;
            if (sel == 3) b = 32'($urandom_range(1, 255));
            run_op("random", o, a, b);
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        wait_idle();
        start = 1'b1; op = 3'd4; operand_A = 32'd1000; operand_B = 32'd7;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 9; i++) next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL flush_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (result_valid === 1'b1) pulses++;
            next_cycle();
        end
        total++;
        if (pulses != 0 || result !== last_res) begin
            bad++; $display("FAIL flush_no_result: pulses=%0d result=%h want 0 pulses result %h", pulses, result, last_res);
        end
        start = 1'b1; flush = 1'b1; op = 3'd0; operand_A = 32'd5; operand_B = 32'd5;
        #1;
        total++;
        if (hold_pipeline !== 1'b0) begin
            bad++; $display("FAIL flush_idle_hold: got %b want 0", hold_pipeline);
        end
        next_cycle();
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_accept: busy=%b want 0", busy);
        end
    endtask

    task automatic test_start_held();
        int pulses = 0, at = 0, lat = 0;
        logic [N-1:0] exp_res;
        exp_res = ref_result(3'd5, 32'd100000, 32'd9);
        wait_idle();
        start = 1'b1; op = 3'd5; operand_A = 32'd100000; operand_B = 32'd9;
        for (int i = 1; i <= N + 2; i++) begin
            next_cycle();
            if (result_valid === 1'b1) begin pulses++; at = i; end
        end
        total++;
        if (pulses != 1 || at != N + 2 || result !== exp_res) begin
            bad++; $display("FAIL held_first: pulses=%0d at=%0d result=%h want 1 at %0d result %h", pulses, at, result, N + 2, exp_res);
        end
        next_cycle();
        total++;
        if (busy !== 1'b0 || hold_pipeline !== 1'b1) begin
            bad++; $display("FAIL held_bubble: busy=%b hold=%b want 0/1", busy, hold_pipeline);
        end
        next_cycle();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL held_reaccept: busy=%b want 1", busy);
        end
        while (result_valid !== 1'b1 && lat < 60) begin next_cycle(); lat++; end
        total++;
        if (lat != N + 1 || result !== exp_res) begin
            bad++; $display("FAIL held_second: wait=%0d result=%h want %0d/%h", lat, result, N + 1, exp_res);
        end
        last_res = exp_res;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        wait_idle();
        start = 1'b1; op = 3'd0; operand_A = 32'd3; operand_B = 32'd4;
        next_cycle();
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || hold_pipeline !== 1'b0) begin
            bad++; $display("FAIL reset_mid: result=%h valid=%b busy=%b dbz=%b hold=%b want all 0", result, result_valid, busy, div_by_zero, hold_pipeline);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (result_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_mid_after: pulses=%0d busy=%b want 0/0", pulses, busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit implementing the RV32IM M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the EX stage beside the combinational ALU and is selected by the decoder for M-type instructions.
- Latches its operands, iterates, and drives hold_pipeline so the pipeline stalls until the result is ready.
- Width and multiply latency are generic. Division is radix-2 restoring, one quotient bit per cycle.

Parameters:
data_width, 32, operand/result width N (even, >=8)
MUL_CYCLES, 2, cycles spent in the MUL state before DONE (>=1)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; accepted only when state is IDLE
flush  input  1  cancels any in-flight op (pipeline flush/exception)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_A  input  N  rs1 value (dividend / multiplicand)
operand_B  input  N  rs2 value (divisor / multiplier)
result  output  N  registered result, valid when result_valid=1
result_valid  output  1  one-cycle pulse in the DONE state
busy  output  1  1 whenever state != IDLE
div_by_zero  output  1  registered with result; 1 if a DIV/DIVU/REM/REMU had operand_B==0
hold_pipeline  output  1  combinational stall request: (start & IDLE & ~flush) | (busy & ~DONE)

Behaviour:
- Reset (rst_n low, async): state=IDLE, result=0, result_valid=0, div_by_zero=0, counters and operand registers = 0.
- States and transitions:
  - IDLE: start & ~flush at edge k latches op, A and B (acceptance), then moves to:
    - MUL for op[2]=0;
    - DONE for the div fast paths below;
    - otherwise DIV.
  - MUL: computes the 2N-bit product using the sign rules below.
    - MUL returns low N bits; MULH, MULHSU, MULHU return high N bits.
    - Stays MUL_CYCLES cycles, then goes to DONE.
    - Latency: result_valid in cycle k+MUL_CYCLES+1.
  - DIV: operates on magnitudes (|A|, |B| for signed ops; raw values for unsigned ops).
    - N iterations driven by a down-counter loaded with N-1; one shift/subtract per cycle.
    - Goes to FIX when the counter reaches 0.
  - FIX: applies signs. Quotient is negated iff A and B signs differ (signed ops). Remainder takes the sign of the dividend. Then goes to DONE.
  - Divide latency: result_valid in cycle k+N+2.
  - DONE: result_valid=1 for exactly one cycle, hold_pipeline=0, then IDLE. result is held until the next DONE.
- Div fast paths (IDLE→DONE directly, latency 1):
  - B==0: quotient = all ones; remainder = A; div_by_zero=1.
  - Signed overflow (A = -2^(N-1), B = -1, DIV/REM): quotient = A; remainder = 0.
- Mul sign rules: MULH treats A and B as signed. MULHSU treats A as signed and B as unsigned. MULHU treats both as unsigned.
- start while busy (including DONE) is ignored. Back-to-back ops therefore carry one IDLE bubble.
- flush:
  - In any non-IDLE state: next state is IDLE, no result_valid, result unchanged.
  - In IDLE, flush suppresses acceptance of a simultaneous start.
- Operands are latched at acceptance; input changes while busy have no effect.
- Async reset mid-operation aborts immediately to reset values. No result_valid follows.

Test Plan:
1. MUL: A=7, B=-3 (0xFFFFFFFD), MUL_CYCLES=2 → result_valid in cycle k+3, result=0xFFFFFFEB. hold_pipeline high in cycles k..k+2 and low in k+3.
2. MULH/MULHSU/MULHU with A=B=0x80000000 → 0x40000000 / 0xC0000000 / 0x40000000 respectively.
3. DIV: A=-20, B=3 → result=-6 (0xFFFFFFFA) valid in cycle k+34. REM on the same operands → -2 (0xFFFFFFFE). DIVU: A=0xFFFFFFFF, B=2 → 0x7FFFFFFF.
4. Divide by zero: DIVU A=123, B=0 → result=0xFFFFFFFF, div_by_zero=1, valid in cycle k+1. REMU on the same operands → 123.
5. Signed overflow: DIV A=0x80000000, B=0xFFFFFFFF → result=0x80000000 at k+1. REM on the same operands → 0.
6. Control:
   - flush asserted in cycle k+10 of a DIV → busy=0 at k+11, no result_valid pulse.
   - start held continuously during a DIV → exactly one result_valid, then re-acceptance in the IDLE cycle after DONE.
   - rst_n low mid-MUL → all outputs zero asynchronously.
